// File: rtl/am9513_issue_sched_if.sv
// am9513_issue_sched_if: submit, issue, execute, completion and sticky-flag signals of the issue scheduler.
// master = requester/datapath side, slave = scheduler.
interface am9513_issue_sched_if #(
    parameter int NUM_CTX = 4,
    parameter int TAG_W   = 8
);
    localparam int CTX_W = $clog2(NUM_CTX);
    logic                 sub_valid, sub_ready;
    logic [CTX_W-1:0]     sub_ctx;
    logic [31:0]          sub_opcode, sub_flags;
    logic [TAG_W-1:0]     sub_tag;
    logic [NUM_CTX*3-1:0] ctx_mode;
    logic                 iss_valid, iss_ready;
    logic [7:0]           iss_func, iss_fmt, iss_src_fmt;
    logic [2:0]           iss_mode;
    logic [4:0]           iss_res_reg;
    logic [CTX_W-1:0]     iss_ctx;
    logic                 exe_done_valid, exe_abort;
    logic [4:0]           exe_done_flags;
    logic                 cpl_valid, cpl_ready;
    logic [CTX_W-1:0]     cpl_ctx;
    logic [TAG_W-1:0]     cpl_tag;
    logic [1:0]           cpl_status;
    logic [4:0]           cpl_flags;
    logic                 flag_clr;
    logic [CTX_W-1:0]     flag_clr_ctx;
    logic [NUM_CTX*5-1:0] sticky_flags;
    logic                 busy;
    modport master (
        output sub_valid, sub_ctx, sub_opcode, sub_flags, sub_tag, ctx_mode, iss_ready,
               exe_done_valid, exe_done_flags, cpl_ready, flag_clr, flag_clr_ctx,
        input  sub_ready, iss_valid, iss_func, iss_fmt, iss_src_fmt, iss_mode, iss_res_reg, iss_ctx,
               exe_abort, cpl_valid, cpl_ctx, cpl_tag, cpl_status, cpl_flags, sticky_flags, busy
    );
    modport slave (
        input  sub_valid, sub_ctx, sub_opcode, sub_flags, sub_tag, ctx_mode, iss_ready,
               exe_done_valid, exe_done_flags, cpl_ready, flag_clr, flag_clr_ctx,
        output sub_ready, iss_valid, iss_func, iss_fmt, iss_src_fmt, iss_mode, iss_res_reg, iss_ctx,
               exe_abort, cpl_valid, cpl_ctx, cpl_tag, cpl_status, cpl_flags, sticky_flags, busy
    );
endinterface

// File: rtl/am9513_issue_sched.sv
// am9513_issue_sched: per-context submit FIFOs, round-robin grant, decode/legality, single-op datapath issue.
// Optional watchdog abort in WAIT enabled by AM9513_SCHED_TIMEOUT_EN.
module am9513_issue_sched #(
    parameter int NUM_CTX        = 4,
    parameter int QDEPTH         = 4,
    parameter int TAG_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic clk,
    input logic rst,
    am9513_issue_sched_if.slave bus
);
    localparam int CTX_W = $clog2(NUM_CTX);
    localparam int PTR_W = $clog2(QDEPTH);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CPL} state_t;
    typedef struct packed {
        logic [31:0]      op;
        logic [31:0]      fl;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t                 mem_q [NUM_CTX][QDEPTH];
    logic [PTR_W:0]       wr_q [NUM_CTX];
    logic [PTR_W:0]       rd_q [NUM_CTX];
    logic [NUM_CTX-1:0]   nempty, full;
    state_t               state_q, state_d;
    logic [CTX_W-1:0]     rr_q, rr_d, grant, idx, ctx_q;
    logic [PTR_W-1:0]     rd_idx;
    ent_t                 head;
    logic [2:0]           mode, mode_q;
    logic [7:0]           func, func_q, fmt_q, src_q;
    logic [4:0]           res_q, cflags_q;
    logic [TAG_W-1:0]     tag_q;
    logic [1:0]           status_q;
    logic [NUM_CTX*5-1:0] sticky_q, sticky_d;
    logic                 push, pop, done, abort, tmo, legal, p0, p1, p2;
    logic                 unused_bits;

    for (genvar i = 0; i < NUM_CTX; i++) begin : g_fifo
        assign nempty[i] = wr_q[i] != rd_q[i];
        assign full[i]   = wr_q[i] == {~rd_q[i][PTR_W], rd_q[i][PTR_W-1:0]};
    end

    // Walk offsets high to low so the nearest non-empty ctx at/after rr_q wins.
    always_comb begin
        grant = rr_q;
        idx   = rr_q;
        for (int k = NUM_CTX - 1; k >= 0; k--) begin
            idx = rr_q + CTX_W'(k);
            if (nempty[idx]) grant = idx;
        end
    end

    assign rd_idx      = rd_q[grant][PTR_W-1:0];
    assign head        = mem_q[grant][rd_idx];
    assign func        = head.op[7:0];
    assign mode        = head.fl[0] ? head.fl[3:1] : bus.ctx_mode[3*grant +: 3];
    assign p0          = (func >= 8'h01 && func <= 8'h05) || func == 8'h10;
    assign p1          = p0 || (func >= 8'h07 && func <= 8'h0A) || (func >= 8'h11 && func <= 8'h14);
    assign p2          = p1 || func == 8'h06 || (func >= 8'h20 && func <= 8'h27);
    assign legal       = head.op[31] && (mode == 3'd0 ? p0 : mode == 3'd1 ? p1 : mode == 3'd2 ? p2 : 1'b0);
    assign unused_bits = ^{head.op[30:16], head.fl[31:12]};
    assign push        = bus.sub_valid && bus.sub_ready;

`ifdef AM9513_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= state_q == S_WAIT ? cnt_q + 1'b1 : '0;
    end
    assign tmo = state_q == S_WAIT && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        pop     = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE:  if (|nempty) begin
                pop     = 1'b1;
                rr_d    = grant + 1'b1;
                state_d = legal ? S_ISSUE : S_CPL;
            end
            S_ISSUE: if (bus.iss_ready) state_d = S_WAIT;
            S_WAIT:  if (bus.exe_done_valid) begin
                done    = 1'b1;
                state_d = S_CPL;
            end else if (tmo) begin
                abort   = 1'b1;
                state_d = S_CPL;
            end
            default: if (bus.cpl_ready) state_d = S_IDLE;
        endcase
    end

    // Clear first, then OR, so a coincident clear+set leaves only the new flags.
    always_comb begin
        sticky_d = sticky_q;
        if (bus.flag_clr) sticky_d[5*bus.flag_clr_ctx +: 5] = 5'd0;
        if (done) sticky_d[5*ctx_q +: 5] = sticky_d[5*ctx_q +: 5] | bus.exe_done_flags;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[bus.sub_ctx][wr_q[bus.sub_ctx][PTR_W-1:0]] <= {bus.sub_opcode, bus.sub_flags, bus.sub_tag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            ctx_q    <= '0;
            func_q   <= '0;
            fmt_q    <= '0;
            src_q    <= '0;
            mode_q   <= '0;
            res_q    <= '0;
            tag_q    <= '0;
            status_q <= '0;
            cflags_q <= '0;
            sticky_q <= '0;
            for (int k = 0; k < NUM_CTX; k++) begin
                wr_q[k] <= '0;
                rd_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            sticky_q <= sticky_d;
            if (push) wr_q[bus.sub_ctx] <= wr_q[bus.sub_ctx] + 1'b1;
            if (pop) begin
                rd_q[grant] <= rd_q[grant] + 1'b1;
                ctx_q       <= grant;
                func_q      <= func;
                fmt_q       <= head.op[15:8];
                src_q       <= head.fl[7:0];
                mode_q      <= mode;
                res_q       <= {head.fl[4], head.fl[11:8]};
                tag_q       <= head.tag;
                status_q    <= legal ? 2'd0 : 2'd2;
                cflags_q    <= '0;
            end
            if (done) begin
                cflags_q <= bus.exe_done_flags;
                status_q <= bus.exe_done_flags != 5'd0 ? 2'd1 : 2'd0;
            end
            if (abort) status_q <= 2'd3;
        end
    end

    assign bus.sub_ready    = ~full[bus.sub_ctx];
    assign bus.iss_valid    = state_q == S_ISSUE;
    assign bus.iss_func     = func_q;
    assign bus.iss_fmt      = fmt_q;
    assign bus.iss_src_fmt  = src_q;
    assign bus.iss_mode     = mode_q;
    assign bus.iss_res_reg  = res_q;
    assign bus.iss_ctx      = ctx_q;
    assign bus.exe_abort    = abort;
    assign bus.cpl_valid    = state_q == S_CPL;
    assign bus.cpl_ctx      = ctx_q;
    assign bus.cpl_tag      = tag_q;
    assign bus.cpl_status   = status_q;
    assign bus.cpl_flags    = cflags_q;
    assign bus.sticky_flags = sticky_q;
    assign bus.busy         = state_q != S_IDLE || |nempty;
endmodule

// File: tb/tb_am9513_issue_sched.sv
// tb_am9513_issue_sched: directed checks of latency, legality, round-robin order, FIFO full, sticky flags and reset.
// Watchdog section follows AM9513_SCHED_TIMEOUT_EN.
module tb_am9513_issue_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    am9513_issue_sched_if #(.NUM_CTX(4), .TAG_W(8)) bus ();
    am9513_issue_sched #(.NUM_CTX(4), .QDEPTH(4), .TAG_W(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic [31:0] op, input logic [31:0] fl, input logic [7:0] tag);
        bus.sub_valid  = 1'b1;
        bus.sub_ctx    = c;
        bus.sub_opcode = op;
        bus.sub_flags  = fl;
        bus.sub_tag    = tag;
        chk("push_ready", bus.sub_ready, 1);
        tick();
        bus.sub_valid = 1'b0;
    endtask

    task automatic wait_iss(input logic [1:0] c, input logic [7:0] f);
        int n = 0;
        while (!bus.iss_valid && n < 20) begin
            tick();
            n++;
        end
        chk("iss_valid", bus.iss_valid, 1);
        chk("iss_ctx", bus.iss_ctx, c);
        chk("iss_func", bus.iss_func, f);
    endtask

    task automatic exec(input logic [4:0] fl);
        bus.iss_ready = 1'b1;
        tick();
        bus.iss_ready      = 1'b0;
        bus.exe_done_valid = 1'b1;
        bus.exe_done_flags = fl;
        tick();
        bus.exe_done_valid = 1'b0;
        bus.exe_done_flags = '0;
    endtask

    task automatic take_cpl(input logic [1:0] c, input logic [7:0] tag, input logic [1:0] st, input logic [4:0] fl);
        int n = 0;
        while (!bus.cpl_valid && n < 20) begin
            tick();
            n++;
        end
        chk("cpl_valid", bus.cpl_valid, 1);
        chk("cpl_ctx", bus.cpl_ctx, c);
        chk("cpl_tag", bus.cpl_tag, tag);
        chk("cpl_status", bus.cpl_status, st);
        chk("cpl_flags", bus.cpl_flags, fl);
        bus.cpl_ready = 1'b1;
        tick();
        bus.cpl_ready = 1'b0;
    endtask

    initial begin
        int acc;
        bus.sub_valid = 0; bus.sub_ctx = 0; bus.sub_opcode = 0; bus.sub_flags = 0; bus.sub_tag = 0;
        bus.ctx_mode = '0; bus.iss_ready = 0; bus.exe_done_valid = 0; bus.exe_done_flags = 0;
        bus.cpl_ready = 0; bus.flag_clr = 0; bus.flag_clr_ctx = 0;
        tick();
        chk("rst_iss_valid", bus.iss_valid, 0);
        chk("rst_cpl_valid", bus.cpl_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sticky", bus.sticky_flags, 0);
        tick();
        rst = 1'b0;
        chk("sub_ready_empty", bus.sub_ready, 1);

        // ADD on ctx0 at P0: issue 2 cycles after handshake, clean completion
        push(2'd0, 32'h8000_0201, 32'h0, 8'h11);
        chk("lat_not_yet", bus.iss_valid, 0);
        chk("busy_queued", bus.busy, 1);
        tick();
        chk("lat_iss_valid", bus.iss_valid, 1);
        chk("add_func", bus.iss_func, 8'h01);
        chk("add_fmt", bus.iss_fmt, 8'h02);
        chk("add_mode", bus.iss_mode, 3'd0);
        chk("add_ctx", bus.iss_ctx, 2'd0);
        exec(5'd0);
        take_cpl(2'd0, 8'h11, 2'd0, 5'd0);
        chk("idle_busy", bus.busy, 0);

        // SIN at P0 is illegal, legal with override mode 2
        push(2'd1, 32'h8000_0220, 32'h0, 8'h22);
        tick();
        chk("ill_no_issue", bus.iss_valid, 0);
        take_cpl(2'd1, 8'h22, 2'd2, 5'd0);
        push(2'd1, 32'h8000_0220, 32'h5, 8'h23);
        wait_iss(2'd1, 8'h20);
        chk("sin_mode", bus.iss_mode, 3'd2);
        exec(5'd0);
        take_cpl(2'd1, 8'h23, 2'd0, 5'd0);

        push(2'd0, 32'h0000_0201, 32'h0, 8'h31);
        take_cpl(2'd0, 8'h31, 2'd2, 5'd0);
        push(2'd0, 32'h8000_0201, 32'h7, 8'h32);
        take_cpl(2'd0, 8'h32, 2'd2, 5'd0);

        // mode 1 override with result register and source format fields
        push(2'd2, 32'h8000_030A, 32'h0A13, 8'h33);
        wait_iss(2'd2, 8'h0A);
        chk("p1_fmt", bus.iss_fmt, 8'h03);
        chk("p1_src", bus.iss_src_fmt, 8'h13);
        chk("p1_mode", bus.iss_mode, 3'd1);
        chk("p1_res", bus.iss_res_reg, 5'h1A);
        exec(5'd0);
        take_cpl(2'd2, 8'h33, 2'd0, 5'd0);

        // round robin from pointer 0 with two ops per ctx
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 2; k++) push(2'(c), 32'h8000_0201, 32'h0, 8'(c * 16 + k));
        for (int i = 0; i < 8; i++) begin
            wait_iss(2'(i % 4), 8'h01);
            exec(5'd0);
            take_cpl(2'(i % 4), 8'((i % 4) * 16 + i / 4), 2'd0, 5'd0);
        end

        // ctx2 FIFO full while a blocker holds the datapath
        push(2'd0, 32'h8000_0201, 32'h0, 8'h40);
        for (int k = 0; k < 4; k++) push(2'd2, 32'h8000_0201, 32'h0, 8'(8'h50 + k));
        bus.sub_ctx = 2'd2;
        #1 chk("full_ctx2", bus.sub_ready, 0);
        bus.sub_ctx = 2'd3;
        #1 chk("ready_ctx3", bus.sub_ready, 1);
        bus.sub_ctx = 2'd2; bus.sub_valid = 1'b1; bus.sub_tag = 8'h54;
        tick();
        bus.sub_valid = 1'b0;
        wait_iss(2'd0, 8'h01);
        exec(5'd0);
        take_cpl(2'd0, 8'h40, 2'd0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            wait_iss(2'd2, 8'h01);
            exec(5'd0);
            take_cpl(2'd2, 8'(8'h50 + k), 2'd0, 5'd0);
        end
        tick();
        chk("full_drop", bus.busy, 0);

        // sticky flags on ctx3
        push(2'd3, 32'h8000_0201, 32'h0, 8'h60);
        wait_iss(2'd3, 8'h01);
        exec(5'b00110);
        take_cpl(2'd3, 8'h60, 2'd1, 5'b00110);
        chk("sticky3_a", bus.sticky_flags[19:15], 5'b00110);
        chk("sticky_other", bus.sticky_flags[14:0], 15'd0);
        push(2'd3, 32'h8000_0201, 32'h0, 8'h61);
        wait_iss(2'd3, 8'h01);
        exec(5'b10000);
        take_cpl(2'd3, 8'h61, 2'd1, 5'b10000);
        chk("sticky3_b", bus.sticky_flags[19:15], 5'b10110);
        push(2'd3, 32'h8000_0201, 32'h0, 8'h62);
        wait_iss(2'd3, 8'h01);
        bus.iss_ready = 1'b1;
        tick();
        bus.iss_ready = 1'b0; bus.exe_done_valid = 1'b1; bus.exe_done_flags = 5'b00001;
        bus.flag_clr = 1'b1; bus.flag_clr_ctx = 2'd3;
        tick();
        bus.exe_done_valid = 1'b0; bus.exe_done_flags = '0; bus.flag_clr = 1'b0;
        chk("sticky3_clr_set", bus.sticky_flags[19:15], 5'b00001);
        take_cpl(2'd3, 8'h62, 2'd1, 5'b00001);
        bus.exe_done_valid = 1'b1; bus.exe_done_flags = 5'h1F;
        tick();
        bus.exe_done_valid = 1'b0; bus.exe_done_flags = '0;
        chk("idle_done_ignored", bus.sticky_flags, 20'h08000);
        chk("idle_done_no_cpl", bus.cpl_valid, 0);

        // asynchronous reset during WAIT with queued ops
        push(2'd0, 32'h8000_0201, 32'h0, 8'h70);
        wait_iss(2'd0, 8'h01);
        bus.iss_ready = 1'b1;
        tick();
        bus.iss_ready = 1'b0;
        for (int c = 1; c < 4; c++) push(2'(c), 32'h8000_0201, 32'h0, 8'(8'h70 + c));
        chk("wait_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_iss_valid", bus.iss_valid, 0);
        chk("arst_iss_func", bus.iss_func, 0);
        chk("arst_cpl_valid", bus.cpl_valid, 0);
        chk("arst_cpl_tag", bus.cpl_tag, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_sticky", bus.sticky_flags, 0);
        chk("arst_abort", bus.exe_abort, 0);
        tick();
        rst = 1'b0;
        bus.exe_done_valid = 1'b1; bus.exe_done_flags = 5'h1F;
        tick();
        bus.exe_done_valid = 1'b0; bus.exe_done_flags = '0;
        chk("late_done_cpl", bus.cpl_valid, 0);
        chk("late_done_sticky", bus.sticky_flags, 0);
        chk("late_done_busy", bus.busy, 0);

        // watchdog behaviour in WAIT
        push(2'd1, 32'h8000_0201, 32'h0, 8'h80);
        wait_iss(2'd1, 8'h01);
        bus.iss_ready = 1'b1;
        tick();
        bus.iss_ready = 1'b0;
        acc = 0;
`ifdef AM9513_SCHED_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            acc += int'(bus.exe_abort);
            tick();
        end
        chk("tmo_early_abort", 32'(acc), 0);
        chk("tmo_abort", bus.exe_abort, 1);
        tick();
        chk("tmo_abort_pulse", bus.exe_abort, 0);
        take_cpl(2'd1, 8'h80, 2'd3, 5'd0);
        chk("tmo_sticky", bus.sticky_flags, 0);
`else
        for (int k = 0; k < 40; k++) begin
            acc += int'(bus.exe_abort) + int'(bus.cpl_valid);
            tick();
        end
        chk("no_tmo_hold", 32'(acc), 0);
        bus.exe_done_valid = 1'b1;
        tick();
        bus.exe_done_valid = 1'b0;
        take_cpl(2'd1, 8'h80, 2'd0, 5'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
